// File: rtl/io_fifo_port_if.sv
// io_fifo_port_if: 8088 bus control strobes and local TX/RX stream signals of io_fifo_port
interface io_fifo_port_if;
  logic        CS;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic        ALE;
  logic [19:0] Address;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  modport master (
    output CS, IOM, RD, WR, ALE, Address, tx_ready, rx_valid, rx_data,
    input  tx_valid, tx_data, rx_ready
  );
  modport slave (
    input  CS, IOM, RD, WR, ALE, Address, tx_ready, rx_valid, rx_data,
    output tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/io_fifo_port.sv
// io_fifo_port: 8088 I/O-mapped mailbox, CPU writes feed a TX FIFO and CPU reads drain an RX FIFO; irq port only with IO_FIFO_IRQ_EN
module io_fifo_port #(
  parameter int DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  io_fifo_port_if.slave bus,
  inout  wire  [7:0]    Data
`ifdef IO_FIFO_IRQ_EN
  ,
  output logic          irq
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_READ, S_WRITE} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_sel;
  logic [7:0]    r_rdata, r_wdata;
  logic          r_rd_pop;
  logic          r_tx_ovf, r_rx_unf;
  logic [1:0]    r_ctrl;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_rp, r_tx_wp, r_rx_rp, r_rx_wp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt, w_tx_cnt_nx, w_rx_cnt_nx;
  logic          r_tx_valid, r_rx_ready;
  logic          w_arm, w_rd_start, w_rd_end, w_wr_end, w_wr_data;
  logic          w_tx_full, w_tx_empty, w_rx_empty;
  logic          w_tx_push, w_tx_pop, w_tx_drop, w_rx_push, w_rx_pop;
  logic [7:0]    w_status, w_count, w_reg;
  logic          w_unused;

  assign w_unused    = ^bus.Address[19:2];
  assign w_tx_full   = r_tx_cnt == FULL;
  assign w_tx_empty  = r_tx_cnt == '0;
  assign w_rx_empty  = r_rx_cnt == '0;
  assign w_arm       = r_state == S_IDLE && w_state_nx == S_ARMED;
  assign w_rd_start  = r_state == S_ARMED && w_state_nx == S_READ;
  assign w_rd_end    = r_state == S_READ && bus.RD;
  assign w_wr_end    = r_state == S_WRITE && bus.WR;
  assign w_wr_data   = w_wr_end && r_sel == 2'd0;
  assign w_tx_pop    = r_tx_valid & bus.tx_ready;
  assign w_tx_push   = w_wr_data & (!w_tx_full | w_tx_pop);
  assign w_tx_drop   = w_wr_data & w_tx_full & !w_tx_pop;
  assign w_rx_push   = bus.rx_valid & r_rx_ready;
  assign w_rx_pop    = w_rd_end & r_rd_pop;
  assign w_tx_cnt_nx = r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
  assign w_rx_cnt_nx = r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
  assign w_status    = {3'b000, w_tx_empty, r_rx_unf, r_tx_ovf, w_tx_full, !w_rx_empty};
  assign w_count     = {4'(r_tx_cnt), 4'(r_rx_cnt)};
  assign w_reg       = r_sel == 2'd0 ? (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]) :
                       r_sel == 2'd1 ? w_status :
                       r_sel == 2'd2 ? {6'b0, r_ctrl} : w_count;

  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_mem[r_tx_rp];
  assign bus.rx_ready = r_rx_ready;
  assign Data         = (r_state == S_READ && !bus.RD) ? r_rdata : 8'hzz;

  // bus cycle state register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // bus cycle decode; a second ALE while armed abandons the cycle
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = (bus.ALE && !bus.CS && bus.IOM) ? S_ARMED : S_IDLE;
      S_ARMED: w_state_nx = bus.ALE ? S_IDLE : !bus.RD ? S_READ : !bus.WR ? S_WRITE : S_ARMED;
      S_READ:  w_state_nx = bus.RD ? S_IDLE : S_READ;
      default: w_state_nx = bus.WR ? S_IDLE : S_WRITE;
    endcase
  end

  // register select, read snapshot, write data capture, CTRL and sticky flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sel    <= 2'd0;
      r_rdata  <= 8'h00;
      r_wdata  <= 8'h00;
      r_rd_pop <= 1'b0;
      r_ctrl   <= 2'b00;
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      if (w_arm) r_sel <= bus.Address[1:0];
      if (w_rd_start) r_rdata <= w_reg;
      if (w_rd_start) r_rd_pop <= r_sel == 2'd0 && !w_rx_empty;
      if (w_rd_start && r_sel == 2'd0 && w_rx_empty) r_rx_unf <= 1'b1;
      if (r_state == S_WRITE && !bus.WR) r_wdata <= Data;
      if (w_tx_drop) r_tx_ovf <= 1'b1;
      if (w_wr_end && r_sel == 2'd2) r_ctrl <= r_wdata[1:0];
      if (w_wr_end && r_sel == 2'd2 && r_wdata[7]) begin
        r_tx_ovf <= 1'b0;
        r_rx_unf <= 1'b0;
      end
    end
  end

  // TX FIFO: CPU pushes at end of write cycle, local consumer pops
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_rp    <= '0;
      r_tx_wp    <= '0;
      r_tx_cnt   <= '0;
      r_tx_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_tx_mem[i] <= 8'h00;
    end else begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= r_wdata;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_valid <= w_tx_cnt_nx != '0;
    end
  end

  // RX FIFO: local producer pushes, CPU pops at end of a DATA read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_rp    <= '0;
      r_rx_wp    <= '0;
      r_rx_cnt   <= '0;
      r_rx_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) r_rx_mem[i] <= 8'h00;
    end else begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_data;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_ready <= w_rx_cnt_nx != FULL;
    end
  end

`ifdef IO_FIFO_IRQ_EN
  // interrupt registered from current FIFO state, trailing any change by one clock
  always_ff @(posedge CLK) begin
    if (RESET) irq <= 1'b0;
    else       irq <= (r_ctrl[0] & !w_rx_empty) | (r_ctrl[1] & w_tx_empty);
  end
`endif
endmodule
